id_ex_stage: RTL and testbench

- ID/EX pipeline register plus operand-forwarding muxes; sits directly upstream of ArithmeticLogicUnit and drives its A, B and ALU_Control inputs.
- Captures decoded operands and control from the decode stage.
- Applies EX/MEM and MEM/WB forwarding.
- Flags load-use hazards back to the hazard unit.
- Supports stall (hold) and flush (bubble insertion).

---
 rtl/id_ex_stage.sv | 203 ++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU, with operand
// forwarding and a load-use hazard flag (optional macro FORWARDING_EN).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   id_*                decoded instruction from the decode stage
//   stall, flush        hold contents / insert a bubble (flush wins)
//   exm_*, wb_*         destination and result of the EX/MEM, MEM/WB stages
//   A, B, ALU_Control   ALU operands and op code
//   store_data          forwarded rt value for stores
//   write_reg           destination register (rd if reg_dst else rt)
//   ex_*                registered valid and control bits
//   load_use_hazard     combinational stall request to the hazard unit
//
// FORWARDING_EN defined: EX/MEM then MEM/WB forwarding, load-use hazard.
// FORWARDING_EN undefined: raw register-file operands, any-RAW hazard.

module id_ex_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_CTRL_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  exm_reg_write,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic [DATA_W-1:0]     exm_result,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]     wb_result,
  output logic [DATA_W-1:0]     A,
  output logic [DATA_W-1:0]     B,
  output logic [ALU_CTRL_W-1:0] ALU_Control,
  output logic [DATA_W-1:0]     store_data,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  load_use_hazard
);

  logic                  valid_q, valid_d;
  logic [DATA_W-1:0]     rd1_q, rd1_d;
  logic [DATA_W-1:0]     rd2_q, rd2_d;
  logic [DATA_W-1:0]     imm_q, imm_d;
  logic [REG_ADDR_W-1:0] rs_q, rs_d;
  logic [REG_ADDR_W-1:0] rt_q, rt_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [ALU_CTRL_W-1:0] ctrl_q, ctrl_d;
  logic                  src_q, src_d;
  logic                  dst_q, dst_d;
  logic                  rw_q, rw_d;
  logic                  mr_q, mr_d;
  logic                  mw_q, mw_d;
  logic                  m2r_q, m2r_d;

  always_comb begin
    valid_d = valid_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rw_d    = rw_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    m2r_d   = m2r_q;
    if (flush) begin
      valid_d = 1'b0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      ctrl_d  = '0;
      src_d   = 1'b0;
      dst_d   = 1'b0;
      rw_d    = 1'b0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      m2r_d   = 1'b0;
    end else if (!stall) begin
      valid_d = id_valid;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      ctrl_d  = id_alu_ctrl;
      // An invalid decode slot enters as a bubble.
      src_d   = id_valid & id_alu_src;
      dst_d   = id_valid & id_reg_dst;
      rw_d    = id_valid & id_reg_write;
      mr_d    = id_valid & id_mem_read;
      mw_d    = id_valid & id_mem_write;
      m2r_d   = id_valid & id_mem_to_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      ctrl_q  <= '0;
      src_q   <= 1'b0;
      dst_q   <= 1'b0;
      rw_q    <= 1'b0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      m2r_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rw_q    <= rw_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      m2r_q   <= m2r_d;
    end
  end

  logic [DATA_W-1:0] a_fwd;
  logic [DATA_W-1:0] rt_fwd;

  assign write_reg = dst_q ? rd_q : rt_q;

`ifdef FORWARDING_EN
  logic exm_a, exm_b, wb_a, wb_b;

  // r0 is hard-wired to zero, so a write to it never forwards.
  assign exm_a = exm_reg_write & (exm_rd != '0) & (exm_rd == rs_q);
  assign exm_b = exm_reg_write & (exm_rd != '0) & (exm_rd == rt_q);
  assign wb_a  = wb_reg_write & (wb_rd != '0) & (wb_rd == rs_q);
  assign wb_b  = wb_reg_write & (wb_rd != '0) & (wb_rd == rt_q);

  // EX/MEM holds the younger value, so it beats MEM/WB.
  assign a_fwd  = exm_a ? exm_result : (wb_a ? wb_result : rd1_q);
  assign rt_fwd = exm_b ? exm_result : (wb_b ? wb_result : rd2_q);

  assign load_use_hazard = valid_q & mr_q & id_valid & (rt_q != '0)
                         & ((rt_q == id_rs) | (rt_q == id_rt));
`else
  logic unused_fwd;

  assign unused_fwd = ^{exm_reg_write, exm_rd, exm_result,
                        wb_reg_write, wb_rd, wb_result, rs_q};

  assign a_fwd  = rd1_q;
  assign rt_fwd = rd2_q;

  // Without forwarding every RAW on a pending write must stall.
  assign load_use_hazard = valid_q & rw_q & id_valid
                         & (write_reg != '0)
                         & ((write_reg == id_rs) | (write_reg == id_rt));
`endif

  assign A             = a_fwd;
  assign B             = src_q ? imm_q : rt_fwd;
  assign store_data    = rt_fwd;
  assign ALU_Control   = ctrl_q;
  assign ex_valid      = valid_q;
  assign ex_reg_write  = rw_q;
  assign ex_mem_read   = mr_q;
  assign ex_mem_write  = mw_q;
  assign ex_mem_to_reg = m2r_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vector table, stall/release sequence and
// randomized run against an instruction-level model of id_ex_stage.

module tb_id_ex_stage;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic        vld;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1, rd2, imm;
    logic [2:0]  ctrl;
    logic        src, dst, rw, mr, mw, m2r;
  } ins_t;

  typedef struct {
    logic        exw;
    logic [4:0]  exrd;
    logic [31:0] exres;
    logic        wbw;
    logic [4:0]  wbrd;
    logic [31:0] wbres;
  } fw_t;

  typedef struct {
    logic [31:0] a, b, sd;
    logic [2:0]  ctrl;
    logic [4:0]  wr;
    logic        v, rw, mr, mw, m2r, hz;
  } exp_t;

  typedef struct {
    logic rst, stall, flush;
    ins_t id;
    fw_t  fw;
    exp_t e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, id_valid;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [2:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_dst, id_reg_write;
  logic        id_mem_read, id_mem_write, id_mem_to_reg;
  logic        stall, flush;
  logic        exm_reg_write, wb_reg_write;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_result, wb_result;
  logic [31:0] A, B, store_data;
  logic [2:0]  ALU_Control;
  logic [4:0]  write_reg;
  logic        ex_valid, ex_reg_write, ex_mem_read;
  logic        ex_mem_write, ex_mem_to_reg, load_use_hazard;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src),
    .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .stall(stall), .flush(flush),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd), .wb_result(wb_result),
    .A(A), .B(B), .ALU_Control(ALU_Control),
    .store_data(store_data), .write_reg(write_reg),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .load_use_hazard(load_use_hazard)
  );

  function automatic ins_t mk_i(int v, int rs, int rt, int rd,
                                logic [31:0] r1, logic [31:0] r2,
                                logic [31:0] im, int c, int s, int d,
                                int rw, int mr, int mw, int m2r);
    ins_t x;
    x.vld = 1'(v);   x.rs = 5'(rs);  x.rt = 5'(rt);  x.rd = 5'(rd);
    x.rd1 = r1;      x.rd2 = r2;     x.imm = im;     x.ctrl = 3'(c);
    x.src = 1'(s);   x.dst = 1'(d);  x.rw = 1'(rw);  x.mr = 1'(mr);
    x.mw = 1'(mw);   x.m2r = 1'(m2r);
    return x;
  endfunction

  function automatic fw_t mk_f(int ew, int erd, logic [31:0] er,
                               int ww, int wrd, logic [31:0] wr);
    fw_t f;
    f.exw = 1'(ew);  f.exrd = 5'(erd);  f.exres = er;
    f.wbw = 1'(ww);  f.wbrd = 5'(wrd);  f.wbres = wr;
    return f;
  endfunction

  function automatic exp_t mk_e(logic [31:0] a, logic [31:0] b,
                                logic [31:0] sd, int c, int wr, int v,
                                int rw, int mr, int mw, int m2r, int hz);
    exp_t e;
    e.a = a;  e.b = b;  e.sd = sd;  e.ctrl = 3'(c);  e.wr = 5'(wr);
    e.v = 1'(v);  e.rw = 1'(rw);  e.mr = 1'(mr);  e.mw = 1'(mw);
    e.m2r = 1'(m2r);  e.hz = 1'(hz);
    return e;
  endfunction

  // ---- reference model: the stage holds one instruction record ----
  ins_t st;

  function automatic ins_t bubble();
    return mk_i(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic ins_t admit(ins_t x);
    ins_t y = x;
    if (!x.vld) begin
      y.src = 0; y.dst = 0; y.rw = 0; y.mr = 0; y.mw = 0; y.m2r = 0;
    end
    return y;
  endfunction

  // Value of register r as seen by EX: the youngest in-flight writer
  // of r wins; otherwise the register file value read in decode.
  function automatic logic [31:0] operand(logic [4:0] r,
                                          logic [31:0] regval, fw_t w);
    logic        pw[2];
    logic [4:0]  pr[2];
    logic [31:0] pv[2];
    if (!FWD || r == 5'd0) return regval;
    pw[0] = w.exw;  pr[0] = w.exrd;  pv[0] = w.exres;
    pw[1] = w.wbw;  pr[1] = w.wbrd;  pv[1] = w.wbres;
    for (int k = 0; k < 2; k++)
      if (pw[k] && pr[k] == r) return pv[k];
    return regval;
  endfunction

  function automatic exp_t predict(ins_t s, fw_t w, ins_t d);
    exp_t        e;
    logic [31:0] rtv;
    logic [4:0]  dest;
    rtv   = operand(s.rt, s.rd2, w);
    dest  = s.dst ? s.rd : s.rt;
    e.a   = operand(s.rs, s.rd1, w);
    e.b   = s.src ? s.imm : rtv;
    e.sd  = rtv;
    e.ctrl = s.ctrl;
    e.wr  = dest;
    e.v   = s.vld;  e.rw = s.rw;  e.mr = s.mr;
    e.mw  = s.mw;   e.m2r = s.m2r;
    if (FWD)
      e.hz = s.vld && s.mr && d.vld && s.rt != 0 &&
             (s.rt == d.rs || s.rt == d.rt);
    else
      e.hz = s.vld && s.rw && d.vld && dest != 0 &&
             (dest == d.rs || dest == d.rt);
    return e;
  endfunction

  function automatic ins_t rnd_ins();
    return mk_i(int'($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                int'($urandom_range(0, 1)));
  endfunction

  function automatic fw_t rnd_fw();
    return mk_f(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                $urandom, int'($urandom_range(0, 1)),
                int'($urandom_range(0, 7)), $urandom);
  endfunction

  task automatic drive(input logic r, input logic s, input logic f,
                       input ins_t x, input fw_t w);
    reset = r;  stall = s;  flush = f;
    id_valid = x.vld;  id_rs = x.rs;  id_rt = x.rt;  id_rd = x.rd;
    id_rd1 = x.rd1;  id_rd2 = x.rd2;  id_imm = x.imm;
    id_alu_ctrl = x.ctrl;  id_alu_src = x.src;  id_reg_dst = x.dst;
    id_reg_write = x.rw;  id_mem_read = x.mr;  id_mem_write = x.mw;
    id_mem_to_reg = x.m2r;
    exm_reg_write = w.exw;  exm_rd = w.exrd;  exm_result = w.exres;
    wb_reg_write = w.wbw;  wb_rd = w.wbrd;  wb_result = w.wbres;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  task automatic chk_all(input string t, input exp_t e);
    chk({t, " A"}, A, e.a);
    chk({t, " B"}, B, e.b);
    chk({t, " store_data"}, store_data, e.sd);
    chk({t, " ALU_Control"}, 32'(ALU_Control), 32'(e.ctrl));
    chk({t, " write_reg"}, 32'(write_reg), 32'(e.wr));
    chk({t, " ex_valid"}, 32'(ex_valid), 32'(e.v));
    chk({t, " ex_reg_write"}, 32'(ex_reg_write), 32'(e.rw));
    chk({t, " ex_mem_read"}, 32'(ex_mem_read), 32'(e.mr));
    chk({t, " ex_mem_write"}, 32'(ex_mem_write), 32'(e.mw));
    chk({t, " ex_mem_to_reg"}, 32'(ex_mem_to_reg), 32'(e.m2r));
    chk({t, " hazard"}, 32'(load_use_hazard), 32'(e.hz));
  endtask

  vec_t tbl[17];
  ins_t i1, i2, i3, i4, i4n, i5, i6, x;
  fw_t  n0, fab, f0b, f55, f55z, w;
  exp_t z, e1, e2, e3, e5;
  logic r, s, f;

  initial begin
    i1  = mk_i(1, 3, 4, 6, 32'h10, 32'h20, 32'h7, 3'b010, 0, 1, 1, 0, 0, 0);
    i2  = mk_i(1, 3, 4, 6, 32'h10, 32'h20, 32'hFFFF_FFFC, 3'b110,
               1, 0, 0, 0, 1, 0);
    i3  = mk_i(1, 1, 5, 0, 32'h100, 32'h200, 32'h8, 3'b010, 1, 0, 1, 1, 0, 1);
    i4  = mk_i(1, 5, 2, 7, 32'h1, 32'h2, 32'h0, 3'b001, 0, 1, 1, 0, 0, 0);
    i4n = i4;
    i4n.vld = 1'b0;
    i5  = mk_i(1, 1, 0, 0, 32'h300, 32'h400, 32'h4, 3'b010, 1, 0, 1, 1, 0, 1);
    i6  = mk_i(0, 3, 4, 6, 32'h10, 32'h20, 32'h7, 3'b010, 0, 0, 1, 0, 0, 0);
    n0   = mk_f(0, 0, 0, 0, 0, 0);
    fab  = mk_f(1, 3, 32'hAA, 1, 3, 32'hBB);
    f0b  = mk_f(1, 0, 32'hAA, 1, 4, 32'hBB);
    f55  = mk_f(0, 0, 0, 1, 4, 32'h55);
    f55z = mk_f(0, 0, 0, 1, 0, 32'h55);
    z  = mk_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e1 = mk_e(32'h10, 32'h20, 32'h20, 3'b010, 6, 1, 1, 0, 0, 0, 0);
    e2 = mk_e(32'h10, 32'hFFFF_FFFC, 32'h20, 3'b110, 4, 1, 0, 0, 1, 0, 0);
    e3 = mk_e(32'h100, 32'h8, 32'h200, 3'b010, 5, 1, 1, 1, 0, 1, 1);
    e5 = mk_e(32'h300, 32'h4, 32'h400, 3'b010, 0, 1, 1, 1, 0, 1, 0);

    tbl[0]  = '{1'b1, 1'b0, 1'b0, i1, n0, z};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, i1, n0, e1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, i1, n0, z};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, i1, n0, z};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, i1, n0, e1};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, i1, fab,
                mk_e(FWD ? 32'hAA : 32'h10, 32'h20, 32'h20, 3'b010,
                     6, 1, 1, 0, 0, 0, 0)};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, i1, f0b,
                mk_e(32'h10, FWD ? 32'hBB : 32'h20, FWD ? 32'hBB : 32'h20,
                     3'b010, 6, 1, 1, 0, 0, 0, 0)};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, i2, f55,
                mk_e(32'h10, 32'hFFFF_FFFC, FWD ? 32'h55 : 32'h20, 3'b110,
                     4, 1, 0, 0, 1, 0, 0)};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, i2, f55z, e2};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, i3, n0, e3};
    tbl[10] = '{1'b0, 1'b1, 1'b0, i4, n0, e3};
    e3.hz = 1'b0;
    tbl[11] = '{1'b0, 1'b1, 1'b0, i4n, n0, e3};
    tbl[12] = '{1'b0, 1'b0, 1'b0, i5, n0, e5};
    tbl[13] = '{1'b0, 1'b1, 1'b0, i4, n0, e5};
    tbl[14] = '{1'b0, 1'b1, 1'b1, i1, n0, z};
    tbl[15] = '{1'b0, 1'b0, 1'b0, i1, n0, e1};
    tbl[16] = '{1'b0, 1'b0, 1'b0, i6, n0,
                mk_e(32'h10, 32'h20, 32'h20, 3'b010, 4, 0, 0, 0, 0, 0, 0)};

    drive(1'b1, 1'b0, 1'b0, i1, n0);
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].flush, tbl[i].id, tbl[i].fw);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].e);
    end

    // Hold for three cycles while decode keeps changing, then release.
    drive(1'b0, 1'b0, 1'b0, i2, n0);
    @(posedge clk);
    #1;
    chk_all("hold_load", e2);
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, rnd_ins(), n0);
      @(posedge clk);
      #1;
      chk_all($sformatf("hold%0d", k), e2);
    end
    drive(1'b0, 1'b0, 1'b0, i4, n0);
    @(posedge clk);
    #1;
    chk_all("release",
            mk_e(32'h1, 32'h2, 32'h2, 3'b001, 7, 1, 1, 0, 0, 0, 0));

    // Randomized run against the model.
    st = bubble();
    for (int n = 0; n < 500; n++) begin
      x = rnd_ins();
      w = rnd_fw();
      r = (n == 0) || ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 4) == 0);
      f = ($urandom_range(0, 9) == 0);
      drive(r, s, f, x, w);
      @(posedge clk);
      if (r || f) st = bubble();
      else if (!s) st = admit(x);
      #1;
      x = rnd_ins();
      w = rnd_fw();
      drive(1'b0, 1'b0, 1'b0, x, w);
      #1;
      chk_all($sformatf("rnd%0d", n), predict(st, w, x));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
